// File: rtl/sfx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : sfx_sequencer
// Description : Square-wave sound-effect player. A rising edge on trigger
//               plays up to NUM_NOTES notes of NOTE_LEN cycles each. Every
//               note has its own half-period (0 = rest). The note table and
//               length are latched at start.
//               Optional feature macro: SFX_LOOP_EN (adds the loop input;
//               when high at the end of the last note the sequence repeats).
// Revision    : 1.0 - initial release
// ============================================================================
module sfx_sequencer #(
    parameter int NUM_NOTES = 4,
    parameter int HP_W      = 17,
    parameter int NOTE_LEN  = 3125000,
    parameter int LEN_W     = $clog2(NUM_NOTES) + 1,
    parameter int RETRIGGER = 1
) (
    input  logic                      clk,
    input  logic                      reset,
`ifdef SFX_LOOP_EN
    input  logic                      loop,
`endif
    input  logic                      trigger,
    input  logic [NUM_NOTES*HP_W-1:0] note_half_period,
    input  logic [LEN_W-1:0]          seq_len,
    output logic                      sound_out,
    output logic                      busy,
    output logic                      done
);

    localparam int DUR_W = $clog2(NOTE_LEN);

    localparam logic [DUR_W-1:0] c_DUR_LAST = DUR_W'(NOTE_LEN - 1);
    localparam logic [DUR_W-1:0] c_DUR_ONE  = DUR_W'(1);
    localparam logic [LEN_W-1:0] c_MAX_LEN  = LEN_W'(NUM_NOTES);
    localparam logic [LEN_W-1:0] c_LEN_ONE  = LEN_W'(1);
    localparam logic [HP_W-1:0]  c_HP_ONE   = HP_W'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PLAY = 1'b1
    } state_t;

    state_t                    state_q, state_d;
    logic                      trig_q;
    logic                      armed_q, armed_d;
    logic [NUM_NOTES*HP_W-1:0] table_q, table_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic [LEN_W-1:0]          note_idx_q, note_idx_d;
    logic [DUR_W-1:0]          dur_cnt_q, dur_cnt_d;
    logic [HP_W-1:0]           tone_cnt_q, tone_cnt_d;
    logic                      sound_q, sound_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic                      w_rise;
    logic                      w_can_start;
    logic                      w_do_start;
    logic                      w_loop;
    logic                      w_dur_end;
    logic                      w_last_note;
    logic [LEN_W-1:0]          w_len_in;
    logic [LEN_W-1:0]          w_idx_nxt;
    logic [HP_W-1:0]           w_cur_hp;
    logic [HP_W-1:0]           w_nxt_hp;

`ifdef SFX_LOOP_EN
    assign w_loop = loop;
`else
    assign w_loop = 1'b0;
`endif

    // armed_q blocks a "rise" caused purely by reset clearing the edge
    // register while trigger is still held high: trigger must be seen low
    // after reset before a new edge counts.
    assign w_rise      = trigger & ~trig_q & armed_q;
    assign w_can_start = w_rise & (seq_len != '0);
    assign w_len_in    = (seq_len > c_MAX_LEN) ? c_MAX_LEN : seq_len;
    assign w_dur_end   = (dur_cnt_q == c_DUR_LAST);
    assign w_last_note = (note_idx_q == (len_q - c_LEN_ONE));
    assign w_idx_nxt   = note_idx_q + c_LEN_ONE;

    // Select half-periods of the current and the following latched note.
    always_comb begin
        w_cur_hp = '0;
        w_nxt_hp = '0;
        for (int i = 0; i < NUM_NOTES; i++) begin
            if (note_idx_q == LEN_W'(i)) begin
                w_cur_hp = table_q[i*HP_W +: HP_W];
            end
            if (w_idx_nxt == LEN_W'(i)) begin
                w_nxt_hp = table_q[i*HP_W +: HP_W];
            end
        end
    end

    // Next-state logic: start/restart, tone generation, note sequencing.
    always_comb begin
        state_d    = state_q;
        armed_d    = armed_q | ~trigger;
        table_d    = table_q;
        len_d      = len_q;
        note_idx_d = note_idx_q;
        dur_cnt_d  = dur_cnt_q;
        tone_cnt_d = tone_cnt_q;
        sound_d    = sound_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        w_do_start = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (w_can_start) begin
                    w_do_start = 1'b1;
                end
            end
            S_PLAY: begin
                if (w_dur_end && w_last_note) begin
                    // Natural completion: a coincident rise starts a fresh
                    // sequence but the finished one still reports done.
                    if (w_can_start) begin
                        w_do_start = 1'b1;
                        done_d     = 1'b1;
                    end else if (w_loop) begin
                        note_idx_d = '0;
                        dur_cnt_d  = '0;
                        tone_cnt_d = '0;
                        sound_d    = (table_q[HP_W-1:0] != '0);
                    end else begin
                        state_d    = S_IDLE;
                        busy_d     = 1'b0;
                        sound_d    = 1'b0;
                        dur_cnt_d  = '0;
                        tone_cnt_d = '0;
                        done_d     = 1'b1;
                    end
                end else if (w_can_start && (RETRIGGER != 0)) begin
                    w_do_start = 1'b1;
                end else if (w_dur_end) begin
                    // Every note begins on its high phase.
                    note_idx_d = w_idx_nxt;
                    dur_cnt_d  = '0;
                    tone_cnt_d = '0;
                    sound_d    = (w_nxt_hp != '0);
                end else begin
                    dur_cnt_d = dur_cnt_q + c_DUR_ONE;
                    if (w_cur_hp != '0) begin
                        if (tone_cnt_q == (w_cur_hp - c_HP_ONE)) begin
                            tone_cnt_d = '0;
                            sound_d    = ~sound_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q + c_HP_ONE;
                        end
                    end else begin
                        sound_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (w_do_start) begin
            state_d    = S_PLAY;
            table_d    = note_half_period;
            len_d      = w_len_in;
            note_idx_d = '0;
            dur_cnt_d  = '0;
            tone_cnt_d = '0;
            busy_d     = 1'b1;
            sound_d    = (note_half_period[HP_W-1:0] != '0);
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            trig_q     <= 1'b0;
            armed_q    <= 1'b0;
            table_q    <= '0;
            len_q      <= '0;
            note_idx_q <= '0;
            dur_cnt_q  <= '0;
            tone_cnt_q <= '0;
            sound_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            trig_q     <= trigger;
            armed_q    <= armed_d;
            table_q    <= table_d;
            len_q      <= len_d;
            note_idx_q <= note_idx_d;
            dur_cnt_q  <= dur_cnt_d;
            tone_cnt_q <= tone_cnt_d;
            sound_q    <= sound_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign sound_out = sound_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_sfx_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_sfx_sequencer
// Description : Self-checking bench for sfx_sequencer. Two instances share
//               all inputs: one with restart-on-retrigger, one without. A
//               cycle-level model (elapsed-cycle position within a playback)
//               predicts sound_out/busy/done for both every cycle.
//               SFX_LOOP_EN, when defined, also exercises the loop input.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sfx_sequencer;

    localparam int NN  = 4;
    localparam int HPW = 8;
    localparam int NL  = 20;
    localparam int LW  = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              trigger = 1'b0;
    logic              loop_s = 1'b0;
    logic [NN*HPW-1:0] nhp = '0;
    logic [LW-1:0]     seq_len = '0;
    logic [1:0]        snd;
    logic [1:0]        bsy;
    logic [1:0]        dn;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sfx_sequencer #(
        .NUM_NOTES(NN), .HP_W(HPW), .NOTE_LEN(NL), .LEN_W(LW), .RETRIGGER(1)
    ) u_rt (
        .clk(clk),
        .reset(reset),
`ifdef SFX_LOOP_EN
        .loop(loop_s),
`endif
        .trigger(trigger),
        .note_half_period(nhp),
        .seq_len(seq_len),
        .sound_out(snd[0]),
        .busy(bsy[0]),
        .done(dn[0])
    );

    sfx_sequencer #(
        .NUM_NOTES(NN), .HP_W(HPW), .NOTE_LEN(NL), .LEN_W(LW), .RETRIGGER(0)
    ) u_nr (
        .clk(clk),
        .reset(reset),
`ifdef SFX_LOOP_EN
        .loop(loop_s),
`endif
        .trigger(trigger),
        .note_half_period(nhp),
        .seq_len(seq_len),
        .sound_out(snd[1]),
        .busy(bsy[1]),
        .done(dn[1])
    );

    // ---------------- model ----------------
    bit m_prev  = 1'b0;
    bit m_armed = 1'b0;
    bit m_play[2];
    int m_k[2];
    int m_len[2];
    int m_tab[2][NN];
    bit m_done[2];
    bit cmp_en = 1'b0;
    int done_cnt[2];

    task automatic check(string nm, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic bit exp_snd(int i);
        int n, o, h;
        if (!m_play[i]) return 1'b0;
        n = m_k[i] / NL;
        o = m_k[i] % NL;
        h = m_tab[i][n];
        if (h == 0) return 1'b0;
        return ((o / h) % 2) == 0;
    endfunction

    task automatic m_start(int i);
        m_len[i]  = (int'(seq_len) > NN) ? NN : int'(seq_len);
        m_k[i]    = 0;
        m_play[i] = 1'b1;
        for (int n = 0; n < NN; n++) m_tab[i][n] = int'(nhp[n*HPW +: HPW]);
    endtask

    task automatic m_step();
        bit rise;
        bit ok;
        if (reset) begin
            m_prev  = 1'b0;
            m_armed = 1'b0;
            for (int i = 0; i < 2; i++) begin
                m_play[i] = 1'b0;
                m_done[i] = 1'b0;
                m_k[i]    = 0;
            end
            return;
        end
        rise    = trigger && !m_prev && m_armed;
        m_armed = m_armed || !trigger;
        m_prev  = trigger;
        ok      = rise && (seq_len != 0);
        for (int i = 0; i < 2; i++) begin
            m_done[i] = 1'b0;
            if (m_play[i]) begin
                if (m_k[i] == m_len[i] * NL - 1) begin
                    if (ok) begin
                        m_start(i);
                        m_done[i] = 1'b1;
                    end else if (loop_s) begin
                        m_k[i] = 0;
                    end else begin
                        m_play[i] = 1'b0;
                        m_done[i] = 1'b1;
                    end
                end else if (ok && i == 0) begin
                    m_start(i);
                end else begin
                    m_k[i]++;
                end
            end else if (ok) begin
                m_start(i);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    // per-cycle comparison against the model
    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            for (int i = 0; i < 2; i++) begin
                string sfx;
                sfx = (i == 0) ? "rt" : "nr";
                check({"cyc_sound_", sfx}, int'(snd[i]), int'(exp_snd(i)));
                check({"cyc_busy_", sfx}, int'(bsy[i]), int'(m_play[i]));
                check({"cyc_done_", sfx}, int'(dn[i]), int'(m_done[i]));
                if (dn[i]) done_cnt[i]++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_tab(int a, int b, int c, int d);
        nhp = {HPW'(d), HPW'(c), HPW'(b), HPW'(a)};
    endtask

    // Raise trigger; returns at the first observation after the rise edge (k=0).
    task automatic fire();
        trigger = 1'b1;
        step(1);
    endtask

    task automatic rel(int n);
        trigger = 1'b0;
        step(n);
    endtask

    initial begin
        int d0;
        reset = 1'b1;
        step(2);
        cmp_en = 1'b1;
        step(1);
        check("reset_busy", int'(bsy[0]), 0);
        check("reset_sound", int'(snd[0]), 0);
        check("reset_done", int'(dn[0]), 0);
        reset = 1'b0;
        step(5);

        // Test 1: tone timing, table {4,2,0,3}
        set_tab(4, 2, 0, 3);
        seq_len = 3'd4;
        fire();
        check("t1_busy_k0", int'(bsy[0]), 1);
        check("t1_snd_k0", int'(snd[0]), 1);
        step(4);  check("t1_snd_k4", int'(snd[0]), 0);
        step(4);  check("t1_snd_k8", int'(snd[0]), 1);
        step(12); check("t1_snd_k20", int'(snd[0]), 1);
        step(2);  check("t1_snd_k22", int'(snd[0]), 0);
        step(18); check("t1_snd_k40", int'(snd[0]), 0);
        step(20); check("t1_snd_k60", int'(snd[0]), 1);
        step(3);  check("t1_snd_k63", int'(snd[0]), 0);
        step(16); check("t1_busy_k79", int'(bsy[0]), 1);
        step(1);
        check("t1_busy_k80", int'(bsy[0]), 0);
        check("t1_done_k80", int'(dn[0]), 1);
        check("t1_snd_k80", int'(snd[0]), 0);
        step(1);  check("t1_done_k81", int'(dn[0]), 0);
        rel(5);

        // Test 2: level held high, zero length, over-long length
        d0 = done_cnt[0];
        fire();
        step(199);
        check("t2_one_done", done_cnt[0] - d0, 1);
        check("t2_idle_after_hold", int'(bsy[0]), 0);
        rel(3);
        seq_len = 3'd0;
        fire();
        step(5);
        check("t2_len0_busy_rt", int'(bsy[0]), 0);
        check("t2_len0_busy_nr", int'(bsy[1]), 0);
        rel(3);
        seq_len = 3'd7;
        fire();
        step(79); check("t2_len7_busy_k79", int'(bsy[0]), 1);
        step(1);
        check("t2_len7_busy_k80", int'(bsy[0]), 0);
        check("t2_len7_done_k80", int'(dn[0]), 1);
        rel(3);

        // Test 3: retrigger at k=35
        seq_len = 3'd4;
        fire();
        step(20);
        trigger = 1'b0;
        step(14);
        trigger = 1'b1;
        step(1);
        check("t3_rt_restart_snd", int'(snd[0]), 1);
        check("t3_nr_no_restart_snd", int'(snd[1]), 0);
        check("t3_rt_busy", int'(bsy[0]), 1);
        step(45);
        check("t3_nr_done_k80", int'(dn[1]), 1);
        check("t3_rt_busy_k80", int'(bsy[0]), 1);
        check("t3_rt_nodone_k80", int'(dn[0]), 0);
        step(35);
        check("t3_rt_done_k115", int'(dn[0]), 1);
        check("t3_rt_busy_k115", int'(bsy[0]), 0);
        rel(3);

        // Test 4: table and length latched
        fire();
        step(5);
        set_tab(1, 1, 1, 1);
        seq_len = 3'd1;
        step(3);  check("t4_snd_k8", int'(snd[0]), 1);
        step(17); check("t4_busy_k25", int'(bsy[0]), 1);
        check("t4_snd_k25", int'(snd[0]), 1);
        step(56);
        rel(3);
        fire();
        check("t4_new_snd_k0", int'(snd[0]), 1);
        step(1);  check("t4_new_snd_k1", int'(snd[0]), 0);
        step(19); check("t4_new_done_k20", int'(dn[0]), 1);
        rel(3);

        // Test 5: reset mid-playback, trigger held
        set_tab(4, 2, 0, 3);
        seq_len = 3'd4;
        fire();
        step(19);
        reset = 1'b1;
        step(1);
        check("t5_busy_after_rst", int'(bsy[0]), 0);
        check("t5_snd_after_rst", int'(snd[0]), 0);
        check("t5_done_after_rst", int'(dn[0]), 0);
        reset = 1'b0;
        step(30);
        check("t5_no_replay_rt", int'(bsy[0]), 0);
        check("t5_no_replay_nr", int'(bsy[1]), 0);
        rel(2);
        fire();
        check("t5_replay_busy", int'(bsy[0]), 1);
        step(81);
        rel(3);

`ifdef SFX_LOOP_EN
        // Test 6: looping two-note sequence
        loop_s  = 1'b1;
        seq_len = 3'd2;
        fire();
        step(40);
        check("t6_loop_snd_k40", int'(snd[0]), 1);
        check("t6_loop_busy_k40", int'(bsy[0]), 1);
        check("t6_loop_nodone_k40", int'(dn[0]), 0);
        step(50);
        loop_s = 1'b0;
        step(30);
        check("t6_done_k120", int'(dn[0]), 1);
        check("t6_busy_k120", int'(bsy[0]), 0);
        rel(3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
